rsa_key_seq: RTL and testbench

- Sequencer for RSA key setup. Accepts primes p, q and public exponent e, and computes n = p*q and phi = (p-1)*(q-1) on one shared iterative multiplier.
- Validates the operands, then drives an external modular-inverse engine over a req/ack handshake to obtain d = e^-1 mod phi.
- Sits between the key-load register interface and the d-calculation datapath. It owns all sequencing and error reporting.

---
 rtl/rsa_pkg.sv | 24 ++
 rtl/shift_add_mul.sv | 71 +++++++
 rtl/rsa_key_seq.sv | 199 +++++++++++++++++++
 tb/tb_rsa_key_seq.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared types for the RSA key-setup sequencer: FSM states, error codes, defaults.
package rsa_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CHECK   = 3'd1,
    S_MUL_N   = 3'd2,
    S_MUL_PHI = 3'd3,
    S_CHECK_E = 3'd4,
    S_INV_REQ = 3'd5,
    S_FINISH  = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    ERR_NONE  = 3'd0,
    ERR_PQ    = 3'd1,
    ERR_E     = 3'd2,
    ERR_NOINV = 3'd3,
    ERR_TMO   = 3'd4
  } err_t;

  localparam int TIMEOUT_DEF = 4096;

endpackage

// File: rtl/shift_add_mul.sv
// Iterative shift-and-add multiplier: the first partial product is formed on the
// load edge, so mul_done is visible at the W-th edge after mul_start is sampled.
module shift_add_mul #(
  parameter int W = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           mul_start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           mul_done,
  output logic [2*W-1:0] prod
);

  localparam int CW = $clog2(W + 1);

  logic [2*W-1:0] acc_q, acc_d;
  logic [2*W-1:0] a_sh_q, a_sh_d;
  logic [W-1:0]   b_sh_q, b_sh_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           run_q, run_d;
  logic           done_q, done_d;

  always_comb begin
    acc_d  = acc_q;
    a_sh_d = a_sh_q;
    b_sh_d = b_sh_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    done_d = 1'b0;
    if (mul_start) begin
      acc_d  = b[0] ? {{W{1'b0}}, a} : '0;
      a_sh_d = {{W{1'b0}}, a} << 1;
      b_sh_d = b >> 1;
      cnt_d  = CW'(W - 1);
      run_d  = 1'b1;
    end else if (run_q) begin
      if (b_sh_q[0]) acc_d = acc_q + a_sh_q;
      a_sh_d = a_sh_q << 1;
      b_sh_d = b_sh_q >> 1;
      cnt_d  = cnt_q - CW'(1);
      // Last remaining partial product: the sum is final after this edge.
      if (cnt_q == CW'(1)) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      a_sh_q <= '0;
      b_sh_q <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      a_sh_q <= a_sh_d;
      b_sh_q <= b_sh_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      done_q <= done_d;
    end
  end

  assign mul_done = done_q;
  assign prod     = acc_q;

endmodule

// File: rtl/rsa_key_seq.sv
// RSA key-setup sequencer: validates p/q/e, forms n and phi on one shared
// multiplier, then obtains d = e^-1 mod phi from an external inverse engine.
module rsa_key_seq
  import rsa_pkg::*;
#(
  parameter int P_W     = 64,
  parameter int N_W     = 2 * P_W,
  parameter int E_W     = 9,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [P_W-1:0] p,
  input  logic [P_W-1:0] q,
  input  logic [E_W-1:0] e,
  output logic           busy,
  output logic           inv_req,
  output logic [E_W-1:0] inv_e,
  output logic [N_W-1:0] inv_phi,
  input  logic           inv_ack,
  input  logic [N_W-1:0] inv_d,
  input  logic           inv_err,
  output logic [N_W-1:0] n,
  output logic [N_W-1:0] d,
  output logic           done,
  output logic [2:0]     err_code,
  output state_t         dbg_state
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  // Inverse handshake: inv_req is high for the whole INV_REQ state with
  // inv_e/inv_phi constant; the engine answers by raising inv_ack for one
  // cycle with inv_d/inv_err valid in that same cycle, and inv_req falls on
  // the following cycle. No ack within TIMEOUT cycles withdraws the request.

  state_t         state_q, state_d;
  logic [P_W-1:0] p_q, p_d, q_q, q_d;
  logic [E_W-1:0] e_q, e_d;
  logic [N_W-1:0] n_q, n_d, phi_q, phi_d, d_q, d_d;
  logic [E_W-1:0] inv_e_q, inv_e_d;
  logic [N_W-1:0] inv_phi_q, inv_phi_d;
  err_t           err_q, err_d;
  logic           mul_start_q, mul_start_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  logic             pq_bad, e_bad;
  logic [P_W-1:0]   mul_a, mul_b;
  logic             mul_done;
  logic [2*P_W-1:0] mul_prod;

  // The multiplier operands follow the state, so MUL_PHI sees (p-1)*(q-1).
  always_comb begin
    mul_a = p_q;
    mul_b = q_q;
    if (state_q == S_MUL_PHI) begin
      mul_a = p_q - P_W'(1);
      mul_b = q_q - P_W'(1);
    end
  end

  shift_add_mul #(.W(P_W)) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .mul_start (mul_start_q),
    .a         (mul_a),
    .b         (mul_b),
    .mul_done  (mul_done),
    .prod      (mul_prod)
  );

  always_comb begin
    state_d     = state_q;
    p_d         = p_q;
    q_d         = q_q;
    e_d         = e_q;
    n_d         = n_q;
    phi_d       = phi_q;
    d_d         = d_q;
    inv_e_d     = inv_e_q;
    inv_phi_d   = inv_phi_q;
    err_d       = err_q;
    mul_start_d = 1'b0;
    tmo_d       = tmo_q;
    pq_bad = !p_q[0] || !q_q[0] || (p_q < P_W'(3)) || (q_q < P_W'(3)) || (p_q == q_q);
    e_bad  = !e_q[0] || (e_q < E_W'(3));
    case (state_q)
      S_IDLE: begin
        if (start) begin
          p_d     = p;
          q_d     = q;
          e_d     = e;
          n_d     = '0;
          d_d     = '0;
          err_d   = ERR_NONE;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (pq_bad) begin
          err_d   = ERR_PQ;
          state_d = S_FINISH;
        end else if (e_bad) begin
          err_d   = ERR_E;
          state_d = S_FINISH;
        end else begin
          mul_start_d = 1'b1;
          state_d     = S_MUL_N;
        end
      end
      S_MUL_N: begin
        if (mul_done) begin
          n_d         = N_W'(mul_prod);
          mul_start_d = 1'b1;
          state_d     = S_MUL_PHI;
        end
      end
      S_MUL_PHI: begin
        if (mul_done) begin
          phi_d   = N_W'(mul_prod);
          state_d = S_CHECK_E;
        end
      end
      S_CHECK_E: begin
        if (N_W'(e_q) >= phi_q) begin
          err_d   = ERR_E;
          state_d = S_FINISH;
        end else begin
          inv_e_d   = e_q;
          inv_phi_d = phi_q;
          tmo_d     = '0;
          state_d   = S_INV_REQ;
        end
      end
      S_INV_REQ: begin
        // An ack arriving in the final timeout cycle still counts.
        if (inv_ack) begin
          if (inv_err) begin
            err_d = ERR_NOINV;
            d_d   = '0;
          end else begin
            d_d = inv_d;
          end
          state_d = S_FINISH;
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          err_d   = ERR_TMO;
          d_d     = '0;
          state_d = S_FINISH;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      p_q         <= '0;
      q_q         <= '0;
      e_q         <= '0;
      n_q         <= '0;
      phi_q       <= '0;
      d_q         <= '0;
      inv_e_q     <= '0;
      inv_phi_q   <= '0;
      err_q       <= ERR_NONE;
      mul_start_q <= 1'b0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      p_q         <= p_d;
      q_q         <= q_d;
      e_q         <= e_d;
      n_q         <= n_d;
      phi_q       <= phi_d;
      d_q         <= d_d;
      inv_e_q     <= inv_e_d;
      inv_phi_q   <= inv_phi_d;
      err_q       <= err_d;
      mul_start_q <= mul_start_d;
      tmo_q       <= tmo_d;
    end
  end

  assign busy      = (state_q != S_IDLE) && (state_q != S_FINISH);
  assign inv_req   = (state_q == S_INV_REQ);
  assign done      = (state_q == S_FINISH);
  assign inv_e     = inv_e_q;
  assign inv_phi   = inv_phi_q;
  assign n         = n_q;
  assign d         = d_q;
  assign err_code  = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_rsa_key_seq.sv
// Bench for rsa_key_seq at P_W=8, TIMEOUT=16: random and directed key setups
// compared against an arithmetic model of the sequencing rules.
module tb_rsa_key_seq;
  import rsa_pkg::*;

  localparam int P_W = 8;
  localparam int N_W = 16;
  localparam int E_W = 9;
  localparam int TMO = 16;
  localparam int REQ_AT = 2 * P_W + 4;
  localparam int XW = 3 + 2 * N_W;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic [P_W-1:0] p, q;
  logic [E_W-1:0] e;
  logic           busy, inv_req, done;
  logic [E_W-1:0] inv_e;
  logic [N_W-1:0] inv_phi, inv_d, n, d;
  logic           inv_ack, inv_err;
  logic [2:0]     err_code;
  state_t         dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [XW-1:0] exp_q[$];
  int primes[$] = '{3, 5, 7, 11, 13, 17, 19, 23, 29, 31, 37, 41, 43, 47, 53, 59, 61, 67,
                    71, 73, 79, 83, 89, 97, 101, 103, 107, 109, 113, 127, 131, 137, 139,
                    149, 151, 157, 163, 167, 173, 179, 181, 191, 193, 197, 199, 211, 223,
                    227, 229, 233, 239, 241, 251};

  rsa_key_seq #(.P_W(P_W), .N_W(N_W), .E_W(E_W), .TIMEOUT(TMO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .p         (p),
    .q         (q),
    .e         (e),
    .busy      (busy),
    .inv_req   (inv_req),
    .inv_e     (inv_e),
    .inv_phi   (inv_phi),
    .inv_ack   (inv_ack),
    .inv_d     (inv_d),
    .inv_err   (inv_err),
    .n         (n),
    .d         (d),
    .done      (done),
    .err_code  (err_code),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint gcd(input longint a, input longint b);
    longint t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  function automatic longint modinv(input longint a, input longint m);
    longint r0 = m, r1 = a % m, s0 = 0, s1 = 1, qt, t;
    while (r1 != 0) begin
      qt = r0 / r1;
      t = r0 - qt * r1; r0 = r1; r1 = t;
      t = s0 - qt * s1; s0 = s1; s1 = t;
    end
    return ((s0 % m) + m) % m;
  endfunction

  // Outcome of one key setup; times are edges after the start-accepting edge.
  task automatic model(input int tp, input int tq, input int te, input int k,
                       output int err, output int xn, output int xd, output int phi,
                       output int req_at, output int done_at);
    err = 0; xn = 0; xd = 0; phi = 0; req_at = -1;
    if (tp % 2 == 0 || tq % 2 == 0 || tp < 3 || tq < 3 || tp == tq) begin
      err = 1; done_at = 1;
    end else if (te % 2 == 0 || te < 3) begin
      err = 2; done_at = 1;
    end else begin
      xn  = tp * tq;
      phi = (tp - 1) * (tq - 1);
      if (te >= phi) begin
        err = 2; done_at = REQ_AT;
      end else begin
        req_at = REQ_AT;
        if (k <= TMO) begin
          done_at = REQ_AT + k;
          if (gcd(te, phi) != 1) err = 3;
          else xd = int'(modinv(te, phi));
        end else begin
          err = 4; done_at = REQ_AT + TMO;
        end
      end
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_inv_req"}, inv_req, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_n"}, n, 0);
    check({tag, "_d"}, d, 0);
    check({tag, "_err"}, err_code, 0);
    check({tag, "_inv_e"}, inv_e, 0);
    check({tag, "_inv_phi"}, inv_phi, 0);
    check({tag, "_state"}, dbg_state, S_IDLE);
  endtask

  // Starts one setup, plays the inverse engine (ack during the k-th request
  // cycle), optionally injects a start while busy or a reset at edge abort_at.
  task automatic trial(input int tp, input int tq, input int te, input int k,
                       input int abort_at, input bit stray);
    int x_err, x_n, x_d, x_phi, x_req, x_done;
    int req_first, req_cnt, done_first, done_cnt, busy_bad, phi_bad, stray_at, dc;
    bit aborted;
    logic [XW-1:0] xv;
    model(tp, tq, te, k, x_err, x_n, x_d, x_phi, x_req, x_done);
    exp_q.push_back({3'(x_err), N_W'(x_n), N_W'(x_d)});
    req_first = -1; req_cnt = 0; done_first = -1; done_cnt = 0;
    busy_bad = 0; phi_bad = 0; aborted = 1'b0;
    stray_at = (stray && x_done > 2) ? int'($urandom_range(1, x_done - 1)) : -1;
    p = P_W'(tp); q = P_W'(tq); e = E_W'(te); start = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i <= x_done + 2 && !aborted; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      start = 1'b0;
      inv_ack = 1'b0;
      if (i == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_zero("abort");
        dc = 0;
        repeat (3) begin
          @(posedge clk); #1;
          if (done) dc++;
        end
        check("abort_no_done", dc, 0);
        rst_n = 1'b1;
        aborted = 1'b1;
      end else begin
        if (inv_req) begin
          if (req_first < 0) req_first = i;
          req_cnt++;
          if (inv_phi != N_W'(x_phi) || inv_e != E_W'(te)) phi_bad++;
          if (req_cnt == k) begin
            inv_ack = 1'b1;
            inv_err = (inv_phi == 0) || (gcd(inv_e, inv_phi) != 1);
            inv_d = inv_err ? N_W'($urandom_range(1, 65535)) : N_W'(modinv(inv_e, inv_phi));
          end
        end
        if (done) begin
          if (done_first < 0) done_first = i;
          done_cnt++;
        end
        if (busy != (i < x_done)) busy_bad++;
        if (i == stray_at) begin
          start = 1'b1;
          p = P_W'($urandom); q = P_W'($urandom); e = E_W'($urandom);
        end
      end
    end
    xv = exp_q.pop_front();
    if (!aborted) begin
      check("err_code", err_code, xv[XW-1 -: 3]);
      check("n", n, xv[2*N_W-1 -: N_W]);
      check("d", d, xv[N_W-1:0]);
      check("done_at", done_first, x_done);
      check("done_pulses", done_cnt, 1);
      check("req_at", req_first, x_req);
      check("req_cycles", req_cnt, (x_req < 0) ? 0 : x_done - x_req);
      check("inv_operands", phi_bad, 0);
      check("busy", busy_bad, 0);
    end
  endtask

  function automatic int pick_pq();
    if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 255));
    return primes[$urandom_range(0, primes.size() - 1)];
  endfunction

  initial begin
    int tp, tq, te;
    rst_n = 1'b0; start = 1'b0; p = '0; q = '0; e = '0;
    inv_ack = 1'b0; inv_d = '0; inv_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    trial(61, 53, 17, 5, -1, 1'b0);
    trial(60, 53, 17, 5, -1, 1'b0);
    trial(53, 53, 17, 5, -1, 1'b0);
    trial(61, 53, 16, 5, -1, 1'b0);
    trial(60, 53, 16, 5, -1, 1'b0);
    trial(3, 5, 9, 5, -1, 1'b0);
    trial(61, 53, 15, 3, -1, 1'b0);
    trial(61, 53, 17, TMO + 5, -1, 1'b0);
    trial(61, 53, 17, TMO, -1, 1'b0);
    trial(61, 53, 17, 5, P_W + 5, 1'b0);
    trial(61, 53, 17, 5, REQ_AT + 2, 1'b0);
    trial(61, 53, 17, 5, -1, 1'b1);

    for (int t = 0; t < 40; t++) begin
      tp = pick_pq();
      tq = (t % 5 == 0) ? tp : pick_pq();
      te = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 511))
                                       : primes[$urandom_range(0, 8)];
      trial(tp, tq, te, int'($urandom_range(1, TMO + 3)), -1, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
